// File: rtl/seq_multiplier_4x4.sv
// rtl/seq_multiplier_4x4.sv - 4x4 unsigned shift-and-add sequential multiplier
// Loads A/B on start, iterates four times, then publishes the 8-bit product.
module seq_multiplier_4x4 (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  output logic out7,
  output logic out6,
  output logic out5,
  output logic out4,
  output logic out3,
  output logic out2,
  output logic out1,
  output logic out0
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [3:0]  m;
  logic [3:0]  q;
  logic [4:0]  p;
  logic [1:0]  cnt;
  logic [7:0]  r;
  logic [4:0]  sum;

  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};
  assign {out7, out6, out5, out4, out3, out2, out1, out0} = r;

  // Partial sum for this iteration; carry lands in sum[4] and is shifted into P[3].
  assign sum = q[0] ? (p + {1'b0, m}) : p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m   <= '0;
      q   <= '0;
      p   <= '0;
      cnt <= '0;
      r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            q   <= b;
            p   <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          p   <= {1'b0, sum[4:1]};
          q   <= {sum[0], q[3:1]};
          cnt <= cnt + 2'd1;
        end
        DONE: begin
          r <= {p[3:0], q};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_4x4.sv
// tb/tb_seq_multiplier_4x4.sv - self-checking bench for seq_multiplier_4x4
// Expected products come from plain integer multiplication of the applied operands.
module tb_seq_multiplier_4x4;

  logic clk;
  logic rst;
  logic start;
  logic A3, A2, A1, A0;
  logic B3, B2, B1, B0;
  logic out7, out6, out5, out4, out3, out2, out1, out0;

  int checks;
  int errors;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs [6];

  seq_multiplier_4x4 dut (
    .clk(clk), .rst(rst), .start(start),
    .A3(A3), .A2(A2), .A1(A1), .A0(A0),
    .B3(B3), .B2(B2), .B1(B1), .B0(B0),
    .out7(out7), .out6(out6), .out5(out5), .out4(out4),
    .out3(out3), .out2(out2), .out1(out1), .out0(out0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] get_out();
    return {out7, out6, out5, out4, out3, out2, out1, out0};
  endfunction

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int prod;
    prod = int'(a) * int'(b);
    return prod[7:0];
  endfunction

  task automatic set_ab(input logic [3:0] a, input logic [3:0] b);
    {A3, A2, A1, A0} = a;
    {B3, B2, B1, B0} = b;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // One operation: verifies the previous product is held through E1..E4 and the new one appears after E5.
  task automatic op_check(input logic [3:0] a, input logic [3:0] b, input string name);
    logic [7:0] prev;
    prev = get_out();
    @(negedge clk);
    set_ab(a, b);
    start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    set_ab(4'($urandom), 4'($urandom));
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold"}, get_out(), prev);
    end
    @(posedge clk);
    #1;
    check(name, get_out(), ref_mul(a, b));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[1] = '{a: 4'd7,  b: 4'd9,  p: 8'h3F};
    vecs[2] = '{a: 4'd12, b: 4'd5,  p: 8'h3C};
    vecs[3] = '{a: 4'd0,  b: 4'd13, p: 8'h00};
    vecs[4] = '{a: 4'd13, b: 4'd0,  p: 8'h00};
    vecs[5] = '{a: 4'd1,  b: 4'd11, p: 8'h0B};

    rst   = 1'b0;
    start = 1'b0;
    set_ab(4'd0, 4'd0);
    #3;
    rst = 1'b1;
    #1;
    check("reset_async", get_out(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("reset_idle", get_out(), 8'h00);

    for (int i = 0; i < 6; i++) begin
      op_check(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_table", i), get_out(), vecs[i].p);
    end

    // Reset shortly after E2 of 9x9 aborts the operation.
    @(negedge clk);
    set_ab(4'd9, 4'd9);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midop_reset", get_out(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midop_no_update", get_out(), 8'h00);
    op_check(4'd9, 4'd9, "fresh_9x9");

    // start held high: ignored while busy, re-sampled at E6 with the A/B present then.
    @(negedge clk);
    set_ab(4'd3, 4'd4);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_ab(4'd5, 4'd6);
    repeat (5) @(posedge clk);
    #1;
    check("held_start_first", get_out(), ref_mul(4'd3, 4'd4));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    set_ab(4'd15, 4'd15);
    repeat (4) @(posedge clk);
    #1;
    check("held_start_hold", get_out(), ref_mul(4'd3, 4'd4));
    @(posedge clk);
    #1;
    check("held_start_second", get_out(), ref_mul(4'd5, 4'd6));

    for (int i = 0; i < 20; i++) begin
      op_check(4'($urandom), 4'($urandom), $sformatf("rand%0d", i));
    end

    // Exhaustive sweep with reset before each load and operand scrambling afterwards.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_ab(4'(a), 4'(b));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_ab(4'($urandom), 4'($urandom));
        repeat (25) @(posedge clk);
        #1;
        check($sformatf("sweep_%0dx%0d", a, b), get_out(), ref_mul(4'(a), 4'(b)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_4x4.md
# seq_multiplier_4x4

Unsigned 4-bit × 4-bit sequential shift-and-add multiplier producing an 8-bit product. A one-cycle `start` request loads operands `A` and `B`. The product is computed over four iterations and then held on `out7..out0` until the next operation completes. It is the top-level arithmetic block of the phase-3 FPGA design. All operand and result bits are exposed as individual scalar ports.

## Interface
- No parameters (fixed 4-bit operands, 8-bit product).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `start`  in  1  operation request, sampled on the rising edge while idle.
- `A3, A2, A1, A0`  in  1 each  operand A, A3 = MSB, unsigned.
- `B3, B2, B1, B0`  in  1 each  operand B, B3 = MSB, unsigned.
- `out7 … out0`  out  1 each  registered product A×B, out7 = MSB.

## Operation
- Internal registers:
  - multiplicand register M (4 b), latched from A.
  - multiplier/low-product shift register Q (4 b), latched from B.
  - accumulator/high-product register P (5 b, including carry).
  - iteration counter (2–3 b).
  - product output register R (8 b), which drives `out7..out0`.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If `start`=1 at the edge: M←A, Q←B, P←0, counter←0, go to CALC.
  - Otherwise remain in IDLE.
- CALC, one iteration per clock:
  - If Q[0]=1, P←P+M (5-bit add, carry kept in P[4]).
  - Then shift {P,Q} right by one as a 9-bit quantity: the P carry bit enters at the top, and the P LSB enters Q[3].
  - Increment the counter.
  - After the 4th iteration, go to DONE.
- DONE: R←{P[3:0],Q}, return to IDLE.
- Arithmetic:
  - Unsigned only; the product always fits in 8 bits (max 15×15 = 225 = 0xE1).
  - No overflow or flag outputs.
- `start` is level-sampled only in IDLE:
  - `start` asserted during CALC/DONE is ignored.
  - `start` still high on the edge the FSM returns to IDLE begins a new operation with the current A/B.
- A/B are sampled only on the loading edge; later changes do not affect the operation in flight.
- R changes only in DONE.
- While busy, outputs keep the previous product; there are no intermediate values on the outputs.

## Timing
- Reset (async, any time): FSM→IDLE, M/Q/P/counter/R←0, so `out7..out0`=0 immediately.
- Deassertion of `rst` must precede the first `start` sampling edge; `start` coincident with a reset release edge is not guaranteed to load.
- Latency:
  - Edge E0: `start` sampled, operands loaded.
  - Edges E1–E4: the four iterations.
  - Edge E5: R updated; product visible on the outputs after E5.
- Throughput: one operation per 6 cycles (E5 back to IDLE; a new `start` can be sampled at E6).
- Reset mid-operation: the operation is aborted, outputs go to 0, and the FSM is in IDLE. No partial result is ever written to R.
- A caller waiting ≥6 cycles after the load edge always sees the final product. The system bench waits 25 cycles.

## Test plan
- Assert `rst` for 1 cycle with no `start` → `out`=0x00, and it remains 0 indefinitely.
- A=15, B=15, `start` for 1 cycle → `out`=0xE1 (225) after the 5th edge, held until the next op.
- A=7, B=9 → 0x3F. Then A=12, B=5 → 0x3C. During the second op, `out` stays 0x3F until its DONE edge.
- A=0, B=13 and A=13, B=0 → 0x00; A=1, B=11 → 0x0B.
- Reset pulse on E2 of A=9×B=9 → `out`=0x00, no later update. A fresh `start` with 9×9 → 0x51.
- Exhaustive sweep: all 256 (A,B) pairs, each as reset + 1-cycle `start` + 25-cycle wait → `out` == A×B for every pair. Toggling A/B after the load edge must not change the result.
